// File: rtl/pe_stream_tx.sv
// pe_stream_tx: GLB-side stream driver for one PE.
// Captures a layer-job config and launches the PE with a one-cycle PE_en pulse.
// Streams filter / ifmap / ipsum words from a single-port SRAM through a
// 2-entry skid FIFO, one phase at a time, and writes returned opsums back.
module pe_stream_tx #(
  parameter int ADDR_W      = 16,
  parameter int DATA_BITS   = 32,
  parameter int CONFIG_SIZE = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  input  logic [ADDR_W-1:0]      filter_base,
  input  logic [ADDR_W-1:0]      ifmap_base,
  input  logic [ADDR_W-1:0]      ipsum_base,
  input  logic [ADDR_W-1:0]      pipsum_base,
  input  logic [ADDR_W-1:0]      opsum_base,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_BITS-1:0]   mem_wdata,
  input  logic [DATA_BITS-1:0]   mem_rdata,
  output logic                   PE_en,
  output logic [CONFIG_SIZE-1:0] i_config,
  output logic [DATA_BITS-1:0]   filter,
  output logic [DATA_BITS-1:0]   ifmap,
  output logic [DATA_BITS-1:0]   depthwise_ipsum,
  output logic [DATA_BITS-1:0]   pointwise_ipsum,
  output logic                   filter_valid,
  output logic                   ifmap_valid,
  output logic                   depthwise_ipsum_valid,
  output logic                   pointwise_ipsum_valid,
  input  logic                   filter_ready,
  input  logic                   ifmap_ready,
  input  logic                   depthwise_ipsum_ready,
  input  logic                   pointwise_ipsum_ready,
  input  logic [DATA_BITS-1:0]   opsum,
  input  logic                   opsum_valid,
  output logic                   opsum_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_FILTER, S_IFMAP, S_IPSUM, S_PIPSUM, S_OPSUM, S_DONE
  } state_t;

  state_t state, state_d;

  logic [CONFIG_SIZE-1:0] cfg_q;
  logic [ADDR_W-1:0]      filter_ptr, ifmap_ptr, ipsum_ptr, pipsum_ptr, opsum_ptr;
  logic [4:0]             col, beats_left, issue_left, next_len;
  logic [DATA_BITS-1:0]   fifo_q [2];
  logic                   wr_idx, rd_idx, rd_inflight;
  logic [1:0]             fifo_cnt;

  // Job shape decoded from the captured config.
  logic       dw;
  logic [4:0] rs_n, u_n, p_n, q_n, f_n;
  assign dw   = cfg_q[12];
  assign rs_n = {3'b0, cfg_q[11:10]} + 5'd1;
  assign u_n  = {4'b0, cfg_q[9]} + 5'd1;
  assign p_n  = {3'b0, cfg_q[8:7]} + 5'd1;
  assign f_n  = cfg_q[6:2];
  assign q_n  = {3'b0, cfg_q[1:0]} + 5'd1;

  logic tx_phase, tx_ready, fifo_valid, tx_pop, rx_acc, beat, last_beat, rd_en;
  logic [ADDR_W-1:0] rd_ptr;

  assign tx_phase   = (state == S_FILTER) || (state == S_IFMAP) ||
                      (state == S_IPSUM)  || (state == S_PIPSUM);
  assign fifo_valid = (fifo_cnt != 2'd0);
  assign tx_pop     = fifo_valid && tx_ready;
  assign rx_acc     = (state == S_OPSUM) && opsum_valid;
  assign beat       = tx_pop || rx_acc;
  assign last_beat  = beat && (beats_left == 5'd1);
  // A pop in this cycle frees a slot, which is what keeps 1 beat/cycle going.
  assign rd_en      = tx_phase && (issue_left != 5'd0) &&
                      (({1'b0, fifo_cnt} + {2'b0, rd_inflight}) < (3'd2 + {2'b0, tx_pop}));

  // Route the current phase's ready in and its read pointer out.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    tx_ready = 1'b0;
    rd_ptr   = '0;
    case (state)
      S_FILTER: begin tx_ready = filter_ready;          rd_ptr = filter_ptr; end
      S_IFMAP:  begin tx_ready = ifmap_ready;           rd_ptr = ifmap_ptr;  end
      S_IPSUM:  begin tx_ready = depthwise_ipsum_ready; rd_ptr = ipsum_ptr;  end
      S_PIPSUM: begin tx_ready = pointwise_ipsum_ready; rd_ptr = pipsum_ptr; end
      default:  ;
    endcase
  end

  // Next-state: phases advance on their last beat; OPSUM loops over columns.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_FILTER;
      S_FILTER: if (last_beat) state_d = S_IFMAP;
      S_IFMAP:  if (last_beat) state_d = S_IPSUM;
      S_IPSUM:  if (last_beat) state_d = dw ? S_PIPSUM : S_OPSUM;
      S_PIPSUM: if (last_beat) state_d = S_OPSUM;
      S_OPSUM:  if (last_beat) state_d = (col == f_n) ? S_DONE : S_IFMAP;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Word count of the phase being entered; IFMAP out of FILTER is column 0.
  always_comb begin
    next_len = 5'd0;
    case (state_d)
      S_FILTER: next_len = p_n * rs_n;
      S_IFMAP:  next_len = (state == S_FILTER) ? rs_n : u_n;
      S_IPSUM:  next_len = dw ? q_n : p_n;
      S_PIPSUM: next_len = p_n;
      S_OPSUM:  next_len = p_n;
      default:  next_len = 5'd0;
    endcase
  end

  // State register.
  // NOTE: flops use non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // Job capture, pointers, beat/issue counters and the skid FIFO.
  // NOTE: the two skid entries are reset with the control logic; they are flops, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q       <= '0;
      filter_ptr  <= '0;
      ifmap_ptr   <= '0;
      ipsum_ptr   <= '0;
      pipsum_ptr  <= '0;
      opsum_ptr   <= '0;
      col         <= '0;
      beats_left  <= '0;
      issue_left  <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cfg_q      <= cfg;
        filter_ptr <= filter_base;
        ifmap_ptr  <= ifmap_base;
        ipsum_ptr  <= ipsum_base;
        pipsum_ptr <= pipsum_base;
        opsum_ptr  <= opsum_base;
        col        <= '0;
      end else if (rd_en) begin
        case (state)
          S_FILTER: filter_ptr <= filter_ptr + ADDR_W'(1);
          S_IFMAP:  ifmap_ptr  <= ifmap_ptr + ADDR_W'(1);
          S_IPSUM:  ipsum_ptr  <= ipsum_ptr + ADDR_W'(1);
          S_PIPSUM: pipsum_ptr <= pipsum_ptr + ADDR_W'(1);
          default:  ;
        endcase
      end
      if (rx_acc) opsum_ptr <= opsum_ptr + ADDR_W'(1);
      if (state == S_OPSUM && last_beat && col != f_n) col <= col + 5'd1;

      rd_inflight <= rd_en;
      if (rd_inflight) begin
        fifo_q[wr_idx] <= mem_rdata;
        wr_idx         <= ~wr_idx;
      end
      if (tx_pop) rd_idx <= ~rd_idx;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, tx_pop};

      if (rd_en) issue_left <= issue_left - 5'd1;
      if (beat)  beats_left <= beats_left - 5'd1;
      if (state_d != state) begin
        beats_left <= next_len;
        issue_left <= (state_d == S_OPSUM) ? 5'd0 : next_len;
      end
    end
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign PE_en       = (state == S_LAUNCH);
  assign i_config    = cfg_q;
  assign opsum_ready = (state == S_OPSUM);

  assign filter_valid          = (state == S_FILTER) && fifo_valid;
  assign ifmap_valid           = (state == S_IFMAP)  && fifo_valid;
  assign depthwise_ipsum_valid = (state == S_IPSUM)  && fifo_valid;
  assign pointwise_ipsum_valid = (state == S_PIPSUM) && fifo_valid;
  assign filter                = fifo_q[rd_idx];
  assign ifmap                 = fifo_q[rd_idx];
  assign depthwise_ipsum       = fifo_q[rd_idx];
  assign pointwise_ipsum       = fifo_q[rd_idx];

  assign mem_en    = rd_en || rx_acc;
  assign mem_we    = rx_acc;
  assign mem_addr  = rx_acc ? opsum_ptr : (rd_en ? rd_ptr : '0);
  assign mem_wdata = rx_acc ? opsum : '0;

endmodule

// File: tb/tb_pe_stream_tx.sv
// tb_pe_stream_tx: randomized scoreboard bench for pe_stream_tx.
// A job model expands each config into the ordered list of beats the PE
// should see; a negedge monitor pops and compares every observed handshake.
module tb_pe_stream_tx;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = 13;
  localparam int K_FILT = 0, K_IFM = 1, K_DWI = 2, K_PWI = 3, K_OPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] cfg = '0;
  logic [AW-1:0] filter_base = '0, ifmap_base = '0, ipsum_base = '0,
                 pipsum_base = '0, opsum_base = '0;
  logic busy, done, mem_en, mem_we, PE_en, opsum_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] i_config;
  logic [DW-1:0] filter, ifmap, depthwise_ipsum, pointwise_ipsum;
  logic filter_valid, ifmap_valid, depthwise_ipsum_valid, pointwise_ipsum_valid;
  logic filter_ready, ifmap_ready, depthwise_ipsum_ready, pointwise_ipsum_ready;
  logic [DW-1:0] opsum = '0;
  logic          opsum_valid = 1'b0;

  logic [3:0]    s_ready = '0;
  logic [3:0]    s_valid;
  logic [DW-1:0] s_data [4];
  assign filter_ready          = s_ready[0];
  assign ifmap_ready           = s_ready[1];
  assign depthwise_ipsum_ready = s_ready[2];
  assign pointwise_ipsum_ready = s_ready[3];
  assign s_valid = {pointwise_ipsum_valid, depthwise_ipsum_valid, ifmap_valid, filter_valid};
  assign s_data[0] = filter;
  assign s_data[1] = ifmap;
  assign s_data[2] = depthwise_ipsum;
  assign s_data[3] = pointwise_ipsum;

  pe_stream_tx #(.ADDR_W(AW), .DATA_BITS(DW), .CONFIG_SIZE(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base), .ipsum_base(ipsum_base),
    .pipsum_base(pipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .PE_en(PE_en), .i_config(i_config),
    .filter(filter), .ifmap(ifmap), .depthwise_ipsum(depthwise_ipsum),
    .pointwise_ipsum(pointwise_ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid),
    .depthwise_ipsum_valid(depthwise_ipsum_valid),
    .pointwise_ipsum_valid(pointwise_ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready),
    .depthwise_ipsum_ready(depthwise_ipsum_ready),
    .pointwise_ipsum_ready(pointwise_ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  typedef struct { int kind; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  exp_t q_exp[$];
  wr_t  q_ops[$];

  int n_cmp = 0, n_bad = 0;
  int exp_beats[5], got_beats[5];
  int pe_cnt = 0, done_cnt = 0;
  int ready_mode = 0;
  logic tog = 1'b0;
  logic [AW-1:0] op_addr_next = '0;
  logic [CW-1:0] cur_cfg = '0;
  logic [3:0]    pend = '0;
  logic [DW-1:0] pend_data [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp_v);
    end
  endtask

  // SRAM contents are a pure function of the address, so data proves addressing.
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= word(mem_addr);

  task automatic push_exp(input int k, input logic [DW-1:0] d);
    q_exp.push_back('{kind: k, data: d});
    exp_beats[k]++;
  endtask

  // Expand a job into its beat sequence straight from the config fields.
  task automatic build_model(input logic [CW-1:0] c, input logic [AW-1:0] fb, ib, pb, ppb);
    int dwm, rs, u, p, f, q;
    logic [AW-1:0] fa, ia, ipa, ppa;
    dwm = int'(c[12]);
    rs  = int'(c[11:10]) + 1;
    u   = int'(c[9]) + 1;
    p   = int'(c[8:7]) + 1;
    f   = int'(c[6:2]);
    q   = int'(c[1:0]) + 1;
    q_exp.delete();
    q_ops.delete();
    for (int k = 0; k < 5; k++) begin exp_beats[k] = 0; got_beats[k] = 0; end
    fa = fb; ia = ib; ipa = pb; ppa = ppb;
    for (int i = 0; i < p * rs; i++) begin push_exp(K_FILT, word(fa)); fa++; end
    for (int col = 0; col <= f; col++) begin
      for (int i = 0; i < ((col == 0) ? rs : u); i++) begin push_exp(K_IFM, word(ia)); ia++; end
      for (int i = 0; i < ((dwm != 0) ? q : p); i++) begin push_exp(K_DWI, word(ipa)); ipa++; end
      if (dwm != 0)
        for (int i = 0; i < p; i++) begin push_exp(K_PWI, word(ppa)); ppa++; end
      for (int i = 0; i < p; i++) push_exp(K_OPS, '0);
    end
  endtask

  // Ready patterns for the PE side plus the opsum producer.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       s_ready = 4'hF;
      1:       begin tog = ~tog; s_ready = {4{tog}}; end
      default: s_ready = 4'($urandom);
    endcase
    if (rst && opsum_ready && (ready_mode == 0 || $urandom_range(0, 3) != 0)) begin
      opsum_valid = 1'b1;
      opsum       = $urandom;
      q_ops.push_back('{addr: op_addr_next, data: opsum});
      op_addr_next++;
    end else if (!opsum_ready) begin
      opsum_valid = 1'($urandom_range(0, 1));
      opsum       = $urandom;
    end else begin
      opsum_valid = 1'b0;
    end
  end

  task automatic on_beat(input int k, input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_t e;
    wr_t  w;
    got_beats[k]++;
    if (q_exp.size() == 0) begin
      check("unexpected_beat_kind", k, 99);
    end else begin
      e = q_exp.pop_front();
      check("beat_kind", k, e.kind);
      if (k == K_OPS) begin
        if (q_ops.size() == 0) check("opsum_write_unexpected", {a, d}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = q_ops.pop_front();
          check("opsum_write", {a, d}, {w.addr, w.data});
        end
      end else if (k == e.kind) begin
        check($sformatf("beat_data_k%0d", k), d, e.data);
      end
    end
  endtask

  // Monitor: handshakes seen at negedge complete at the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      pend = '0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (pend[s]) check($sformatf("hold_s%0d", s), {s_valid[s], s_data[s]}, {1'b1, pend_data[s]});
        pend[s]      = s_valid[s] && !s_ready[s];
        pend_data[s] = s_data[s];
      end
      if (|s_valid) check("single_valid", $countones(s_valid), 1);
      for (int s = 0; s < 4; s++)
        if (s_valid[s] && s_ready[s]) on_beat(s, s_data[s], '0);
      if (mem_en && mem_we) on_beat(K_OPS, mem_wdata, mem_addr);
      if (PE_en) pe_cnt++;
      if (done) begin
        check("done_all_beats", q_exp.size(), 0);
        check("pe_en_pulses", pe_cnt, 1);
        pe_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic recover_reset();
    rst = 1'b0;
    #1;
    q_exp.delete();
    q_ops.delete();
    pe_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic launch(input logic [CW-1:0] c, input logic [AW-1:0] fb, ib, pb, ppb, ob);
    build_model(c, fb, ib, pb, ppb);
    op_addr_next = ob;
    cur_cfg      = c;
    @(posedge clk); #2;
    cfg = c; filter_base = fb; ifmap_base = ib; ipsum_base = pb;
    pipsum_base = ppb; opsum_base = ob; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("launch_state", {busy, PE_en, done, i_config}, {1'b1, 1'b1, 1'b0, c});
    // Scramble the inputs: the job must run from what was captured.
    cfg = ~c;
    filter_base = 16'($urandom); ifmap_base = 16'($urandom); ipsum_base = 16'($urandom);
    pipsum_base = 16'($urandom); opsum_base = 16'($urandom);
  endtask

  task automatic wait_done(input bit poke);
    int  d0;
    bit  ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (poke && i == 6) start = 1'b1;
      if (done) begin
        check("cfg_held", i_config, cur_cfg);
        if (poke) start = 1'b1;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    start = 1'b0;
    check("done_seen", ok, 1);
    if (!ok) recover_reset();
    repeat (3) @(posedge clk);
    #2;
    check("idle_after_done", {busy, PE_en}, 0);
    check("no_relaunch", pe_cnt, 0);
    check("done_pulses", done_cnt - d0, ok ? 1 : 0);
    for (int k = 0; k < 5; k++)
      check($sformatf("beat_count_k%0d", k), got_beats[k], exp_beats[k]);
    check("opsum_queue_empty", q_ops.size(), 0);
  endtask

  task automatic run_job(input logic [CW-1:0] c, input logic [AW-1:0] fb, ib, pb, ppb, ob,
                         input int mode, input bit poke);
    ready_mode = mode;
    launch(c, fb, ib, pb, ppb, ob);
    wait_done(poke);
  endtask

  initial begin
    int d0;
    bit seen;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ctrl_outputs",
          {busy, done, PE_en, s_valid, opsum_ready, mem_en, mem_we, mem_addr, i_config}, 0);
    check("reset_stream_data", {s_data[0], mem_wdata}, 0);
    rst = 1'b1;

    // Conv: rs=3 U=2 p=2 F=1 q=3.
    run_job(13'h0A86, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0800, 0, 1'b0);
    // Depthwise: rs=3 U=1 p=2 F=0 q=3.
    run_job(13'h1882, 16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1400, 0, 1'b0);
    // 16 filter beats under 1010 ready backpressure.
    run_job(13'h0D84, 16'h2000, 16'h2100, 16'h2200, 16'h2300, 16'h2400, 1, 1'b0);
    // Stride U=2, F=2: ifmap beats 3,2,2.
    run_job(13'h0A08, 16'h3000, 16'h3100, 16'h3200, 16'h3300, 16'h3400, 0, 1'b0);
    // Start pokes while busy and at DONE, then a fresh job from new bases.
    run_job(13'h0A86, 16'h4000, 16'h4100, 16'h4200, 16'h4300, 16'h4400, 2, 1'b1);
    run_job(13'h1882, 16'h5000, 16'h5100, 16'h5200, 16'h5300, 16'h5400, 2, 1'b0);

    // Reset in the middle of FILTER.
    ready_mode = 0;
    d0 = done_cnt;
    launch(13'h0D84, 16'h6000, 16'h6100, 16'h6200, 16'h6300, 16'h6400);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (filter_valid) begin seen = 1'b1; break; end
    end
    check("filter_started", seen, 1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {busy, done, PE_en, s_valid, opsum_ready, mem_en, i_config}, 0);
    q_exp.delete();
    q_ops.delete();
    pe_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check("no_done_on_abort", done_cnt - d0, 0);
    run_job(13'h0A86, 16'h7000, 16'h7100, 16'h7200, 16'h7300, 16'h7400, 0, 1'b0);

    // Largest job with every pointer crossing the top of the address space.
    run_job(13'h1FFF, 16'hFFFC, 16'hFFF0, 16'hFFF8, 16'hFFFA, 16'hFFFE, 2, 1'b0);

    for (int j = 0; j < 6; j++)
      run_job(13'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
